shifter_stage: RTL and testbench

Registered shifter and flag stage directly downstream of the ALU in the datapath. It accepts the ALU result with a valid/ready handshake and applies the microinstruction's shift operation. It captures the N/Z condition bits and buffers up to two results for the C-bus writeback consumer. It also holds the persistent N/Z flip-flops read by the microsequencer's conditional jumps.

---
 rtl/shifter_stage_pkg.sv | 25 ++
 rtl/shifter_stage_buf.sv | 69 ++++++
 rtl/shifter_stage.sv | 96 +++++++++
 tb/tb_shifter_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_stage_pkg.sv
// -----------------------------------------------------------------------------
// shifter_stage_pkg
// Shared definitions for the post-ALU shifter/flag stage:
//   NBITS       datapath width
//   shift_op_t  microinstruction shift field encoding
//   entry_t     one buffered result {C-bus value, N, Z}
// -----------------------------------------------------------------------------
package shifter_stage_pkg;

  localparam int NBITS = 32;

  // 2'b11 is reserved and is treated as SH_PASS by the stage.
  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_SLL8 = 2'b01,
    SH_SRA1 = 2'b10
  } shift_op_t;

  typedef struct packed {
    logic [NBITS-1:0] c;
    logic             n;
    logic             z;
  } entry_t;

endpackage : shifter_stage_pkg

// File: rtl/shifter_stage_buf.sv
// -----------------------------------------------------------------------------
// shift_buf
// Generic 2-entry in-order valid/ready FIFO, parameterised on the entry type.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and head entry
// in_ready_o and out_valid_o decode the count register only, so there is no
// combinational path from out_ready_i to in_ready_o.
// -----------------------------------------------------------------------------
module shift_buf #(
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  entry_t in_data_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t out_data_o
);

  entry_t     mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    // Simultaneous push and pop leave the occupancy unchanged.
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the storage is only two entries and must read as zero after
      // reset (out_c is observable while empty), so it is reset explicitly.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule : shift_buf

// File: rtl/shifter_stage.sv
// -----------------------------------------------------------------------------
// shifter_stage
// Registered shifter and flag stage downstream of the ALU.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   ALU-side handshake (in_ready from registered state)
//   alu_y, shift_op      ALU result and shift operation (00 PASS, 01 SLL8,
//                        10 SRA1, 11 PASS)
//   out_valid, out_ready C-bus writeback handshake
//   out_c, out_n, out_z  head entry: shifted value and its N/Z bits
//   n_flag, z_flag       persistent flags, loaded when an entry departs
// -----------------------------------------------------------------------------
module shifter_stage
  import shifter_stage_pkg::*;
#(
  // Must match shifter_stage_pkg::NBITS, which sizes entry_t.
  parameter int NBITS = shifter_stage_pkg::NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] alu_y,
  input  logic [1:0]       shift_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_c,
  output logic             out_n,
  output logic             out_z,
  output logic             n_flag,
  output logic             z_flag
);

  function automatic logic [NBITS-1:0] apply_shift(input logic [1:0]       op,
                                                   input logic [NBITS-1:0] y);
    logic [NBITS-1:0] r;
    case (op)
      SH_SLL8: r = {y[NBITS-9:0], 8'h00};
      SH_SRA1: r = {y[NBITS-1], y[NBITS-1:1]};
      default: r = y;  // SH_PASS and the reserved encoding
    endcase
    return r;
  endfunction

  entry_t in_entry;
  entry_t head;
  logic   n_flag_q, n_flag_d;
  logic   z_flag_q, z_flag_d;

  // Flags describe the ALU result itself, not the shifted value.
  always_comb begin
    in_entry.c = apply_shift(shift_op, alu_y);
    in_entry.n = alu_y[NBITS-1];
    in_entry.z = (alu_y == '0);
  end

  shift_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );

  assign out_c = head.c;
  assign out_n = head.n;
  assign out_z = head.z;

  always_comb begin
    n_flag_d = n_flag_q;
    z_flag_d = z_flag_q;
    if (out_valid && out_ready) begin
      n_flag_d = head.n;
      z_flag_d = head.z;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      n_flag_q <= n_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  assign n_flag = n_flag_q;
  assign z_flag = z_flag_q;

endmodule : shifter_stage

// File: tb/tb_shifter_stage.sv
// -----------------------------------------------------------------------------
// tb_shifter_stage
// Directed bench for shifter_stage. Inputs change and outputs are sampled 1ns
// after each rising edge; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shifter_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_y;
  logic [1:0]  shift_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic        out_n;
  logic        out_z;
  logic        n_flag;
  logic        z_flag;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  shifter_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_y     (alu_y),
    .shift_op  (shift_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_n     (out_n),
    .out_z     (out_z),
    .n_flag    (n_flag),
    .z_flag    (z_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    alu_y     = 32'hDEADBEEF;
    shift_op  = 2'b00;
    out_ready = 1'b1;
    #2;  // before the first rising edge at 5ns
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_c !== 32'h0)    $display("FAIL reset_out_c: got %h want 00000000", out_c); else passed++;
    checks++; if (out_n !== 1'b0 || out_z !== 1'b0) $display("FAIL reset_out_nz: got %b%b want 00", out_n, out_z); else passed++;
    checks++; if (n_flag !== 1'b0 || z_flag !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", n_flag, z_flag); else passed++;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sll8();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_y     = 32'h000000AB;
    shift_op  = 2'b01;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1)      $display("FAIL sll8_valid: got %b want 1", out_valid); else passed++;
    checks++; if (out_c !== 32'h0000AB00)  $display("FAIL sll8_c: got %h want 0000ab00", out_c); else passed++;
    checks++; if (out_n !== 1'b0 || out_z !== 1'b0) $display("FAIL sll8_nz: got %b%b want 00", out_n, out_z); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0)      $display("FAIL sll8_popped: got %b want 0", out_valid); else passed++;
    checks++; if (n_flag !== 1'b0 || z_flag !== 1'b0) $display("FAIL sll8_flags: got %b%b want 00", n_flag, z_flag); else passed++;
  endtask

  task automatic test_sra1_negative();
    in_valid = 1'b1;
    alu_y    = 32'h80000002;
    shift_op = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++; if (out_c !== 32'hC0000001) $display("FAIL sra1_c: got %h want c0000001", out_c); else passed++;
    checks++; if (out_n !== 1'b1)         $display("FAIL sra1_out_n: got %b want 1", out_n); else passed++;
    checks++; if (n_flag !== 1'b0)        $display("FAIL sra1_flag_before_pop: got %b want 0", n_flag); else passed++;
    tick();
    checks++; if (n_flag !== 1'b1 || z_flag !== 1'b0) $display("FAIL sra1_flags: got %b%b want 10", n_flag, z_flag); else passed++;
  endtask

  task automatic test_zero_reserved();
    in_valid = 1'b1;
    alu_y    = 32'h00000000;
    shift_op = 2'b11;
    tick();
    in_valid = 1'b0;
    checks++; if (out_c !== 32'h0)        $display("FAIL zero_c: got %h want 00000000", out_c); else passed++;
    checks++; if (out_z !== 1'b1 || out_n !== 1'b0) $display("FAIL zero_nz: got %b%b want 01", out_n, out_z); else passed++;
    tick();
    checks++; if (z_flag !== 1'b1 || n_flag !== 1'b0) $display("FAIL zero_flags: got %b%b want 01", n_flag, z_flag); else passed++;
    in_valid = 1'b1;
    alu_y    = 32'h00000100;
    shift_op = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++; if (out_c !== 32'h00000080) $display("FAIL sra1_pos_c: got %h want 00000080", out_c); else passed++;
    checks++; if (z_flag !== 1'b1)        $display("FAIL z_flag_hold: got %b want 1", z_flag); else passed++;
    tick();
    checks++; if (z_flag !== 1'b0)        $display("FAIL z_flag_clear: got %b want 0", z_flag); else passed++;
  endtask

  // One result per cycle with out_ready high; includes bit-dropping edge cases.
  task automatic test_back_to_back();
    logic [31:0] vec_y   [4] = '{32'hFF123456, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    logic [1:0]  vec_op  [4] = '{2'b01, 2'b10, 2'b10, 2'b00};
    logic [31:0] exp_c   [4] = '{32'h12345600, 32'h3FFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    logic        exp_n   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      alu_y    = vec_y[i];
      shift_op = vec_op[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_c !== exp_c[i] || out_n !== exp_n[i])
        $display("FAIL b2b_%0d: got v=%b r=%b c=%h n=%b want v=1 r=1 c=%h n=%b",
                 i, out_valid, in_ready, out_c, out_n, exp_c[i], exp_n[i]);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || n_flag !== 1'b0 || z_flag !== 1'b0)
      $display("FAIL b2b_drain: got v=%b nz=%b%b want v=0 nz=00", out_valid, n_flag, z_flag); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    shift_op  = 2'b00;
    in_valid  = 1'b1;
    alu_y     = 32'h1;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", in_ready); else passed++;
    alu_y = 32'h2;
    tick();
    alu_y = 32'h3;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else passed++;
    tick();
    checks++; if (in_ready !== 1'b0 || out_c !== 32'h1) $display("FAIL bp_hold: got r=%b c=%h want r=0 c=00000001", in_ready, out_c); else passed++;
    out_ready = 1'b1;
    tick();  // pops 0x1; no push since in_ready was low
    checks++; if (out_c !== 32'h2 || in_ready !== 1'b1) $display("FAIL bp_second: got c=%h r=%b want c=00000002 r=1", out_c, in_ready); else passed++;
    tick();  // pops 0x2, pushes 0x3
    in_valid = 1'b0;
    checks++; if (out_c !== 32'h3 || out_valid !== 1'b1) $display("FAIL bp_third: got c=%h v=%b want c=00000003 v=1", out_c, out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_midstream();
    // Leave n_flag set so the reset clearing it is observable.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_y     = 32'h80000000;
    shift_op  = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (n_flag !== 1'b1) $display("FAIL mid_flag_setup: got %b want 1", n_flag); else passed++;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_y     = 32'hA;
    tick();
    alu_y = 32'hB;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL mid_full: got r=%b v=%b want r=0 v=1", in_ready, out_valid); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_c !== 32'h0 || n_flag !== 1'b0)
      $display("FAIL mid_reset: got v=%b r=%b c=%h n=%b want v=0 r=1 c=00000000 n=0", out_valid, in_ready, out_c, n_flag); else passed++;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_y     = 32'h55;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_c !== 32'h55) $display("FAIL mid_first_out: got v=%b c=%h want v=1 c=00000055", out_valid, out_c); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_drain: got %b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_sll8();
    test_sra1_negative();
    test_zero_reserved();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_shifter_stage
